// File: rtl/fabric_stream_rx.sv
// fabric_stream_rx: 2-entry skid buffer receiving a valid/ready fabric stream,
// with an optional sticky protocol checker on the upstream side.
// Build option: define FABRIC_STREAM_RX_CHECK_EN to compile in the checker;
// without it err_valid/err_code are tied low and err_clear is ignored.
module fabric_stream_rx #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ERR_WIDTH = 16,
   parameter logic [ERR_WIDTH-1:0] ERR_VALID_DROP = ERR_WIDTH'(16'h0101),
   parameter logic [ERR_WIDTH-1:0] ERR_DATA_CHANGE = ERR_WIDTH'(16'h0102)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 err_valid,
   output logic [ERR_WIDTH-1:0] err_code,
   input  logic                 err_clear
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_d;
   logic [WIDTH-1:0] skid;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_d;
   logic             in_ready_d;
   logic             out_valid_d;
   logic             accept;
   logic             pop;

   // Occupancy next-state, register loads and next handshake flags
   always_comb begin
      state_d = state;
      main_d  = out_data;
      skid_d  = skid;
      accept  = in_valid & in_ready;
      pop     = out_valid & out_ready;
      case (state)
         S_EMPTY: begin
            if (accept) begin
               state_d = S_ONE;
               main_d  = in_data;
            end
         end
         S_ONE: begin
            if (accept && pop) begin
               main_d = in_data;
            end else if (accept) begin
               state_d = S_TWO;
               skid_d  = in_data;
            end else if (pop) begin
               state_d = S_EMPTY;
            end
         end
         S_TWO: begin
            if (pop) begin
               state_d = S_ONE;
               main_d  = skid;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      in_ready_d  = (state_d != S_TWO);
      out_valid_d = (state_d != S_EMPTY);
   end

   // State, payload registers and registered handshake outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_EMPTY;
         out_data  <= '0;
         skid      <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_d;
         out_data  <= main_d;
         skid      <= skid_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
      end
   end

`ifdef FABRIC_STREAM_RX_CHECK_EN
   logic                 live;
   logic                 stall;
   logic [WIDTH-1:0]     prev_data;
   logic                 violation;
   logic [ERR_WIDTH-1:0] viol_code;
   logic                 err_valid_d;
   logic [ERR_WIDTH-1:0] err_code_d;

   // Violation detection and sticky capture; a new violation beats a clear
   always_comb begin
      err_valid_d = err_valid;
      err_code_d  = err_code;
      violation   = stall & (~in_valid | (in_data != prev_data));
      viol_code   = in_valid ? ERR_DATA_CHANGE : ERR_VALID_DROP;
      if (violation && (!err_valid || err_clear)) begin
         err_valid_d = 1'b1;
         err_code_d  = viol_code;
      end else if (err_clear) begin
         err_valid_d = 1'b0;
         err_code_d  = '0;
      end
   end

   // Stall history (ignoring the first post-reset cycle) and error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live      <= 1'b0;
         stall     <= 1'b0;
         prev_data <= '0;
         err_valid <= 1'b0;
         err_code  <= '0;
      end else begin
         live      <= 1'b1;
         stall     <= live & in_valid & ~in_ready;
         prev_data <= in_data;
         err_valid <= err_valid_d;
         err_code  <= err_code_d;
      end
   end
`else
   logic unused_err_clear;

   assign err_valid        = 1'b0;
   assign err_code         = '0;
   assign unused_err_clear = err_clear;
`endif

endmodule
